// File: rtl/me_pkg.sv
// Shared types, widths and the saturating adder for the motion-estimation SAD datapath.
`default_nettype none

package me_pkg;

  localparam int SAD_W = 14;
  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Unsigned add clamped to 2^width-1; operands and width must stay below 32 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sad_lane.sv
// One candidate lane: |cur - ref| feeding a saturating accumulator; acc_nxt is the value the lane takes next edge.
`default_nettype none

module sad_lane
  import me_pkg::*;
#(
  parameter int BIT_WIDTH = SAD_W,
  parameter int PIX_WIDTH = PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PIX_WIDTH-1:0] cur,
  input  logic [PIX_WIDTH-1:0] ref_pix,
  output logic [BIT_WIDTH-1:0] acc_nxt
);

  logic signed [PIX_WIDTH:0] diff;
  logic        [PIX_WIDTH:0] mag;
  logic        [PIX_WIDTH-1:0] abs_diff;
  logic        [BIT_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    diff     = $signed({1'b0, cur}) - $signed({1'b0, ref_pix});
    mag      = diff[PIX_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    abs_diff = mag[PIX_WIDTH-1:0];
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = BIT_WIDTH'(sat_add(32'(acc_q), 32'(abs_diff), BIT_WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_nxt = acc_d;

endmodule

`default_nettype wire

// File: rtl/sad_accumulator.sv
// Block SAD accumulator: NUM_CAND parallel lanes over PIXELS beats, result held until the comparator tree takes it.
`default_nettype none

module sad_accumulator
  import me_pkg::*;
#(
  parameter int BIT_WIDTH = SAD_W,
  parameter int PIX_WIDTH = PIX_W,
  parameter int NUM_CAND  = 4,
  parameter int PIXELS    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_WIDTH-1:0]          cur_pix,
  input  logic [NUM_CAND*PIX_WIDTH-1:0] ref_pix,
  output logic                          sad_valid,
  input  logic                          sad_ready,
  output logic [NUM_CAND*BIT_WIDTH-1:0] sad,
  output logic                          busy
);

  localparam int CNT_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_CAND*BIT_WIDTH-1:0] sad_q, sad_d;
  logic                          sad_valid_q, sad_valid_d;
  logic [NUM_CAND*BIT_WIDTH-1:0] acc_nxt_all;
  logic                          accept, lane_clr, lane_en, last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAND; gi++) begin : g_lane
      sad_lane #(
        .BIT_WIDTH(BIT_WIDTH),
        .PIX_WIDTH(PIX_WIDTH)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .clr    (lane_clr),
        .en     (lane_en),
        .cur    (cur_pix),
        .ref_pix(ref_pix[gi*PIX_WIDTH +: PIX_WIDTH]),
        .acc_nxt(acc_nxt_all[gi*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  endgenerate

  always_comb begin
    accept      = in_valid && (state_q == ACCUM);
    // start wins over a coincident beat, and is ignored while a result is held
    lane_clr    = start && (state_q != HOLD);
    lane_en     = accept && !start;
    last_beat   = lane_en && (cnt_q == CNT_W'(PIXELS - 1));
    state_d     = state_q;
    cnt_d       = cnt_q;
    sad_d       = sad_q;
    sad_valid_d = sad_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (start) begin
          cnt_d = '0;
        end else if (last_beat) begin
          cnt_d       = '0;
          state_d     = HOLD;
          sad_d       = acc_nxt_all;
          sad_valid_d = 1'b1;
        end else if (lane_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (sad_ready) begin
          state_d     = IDLE;
          sad_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        sad_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign sad       = sad_q;
  assign sad_valid = sad_valid_q;

endmodule

`default_nettype wire
